// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - time-of-day and alarm field counters with RUN/SET_TIME/SET_ALARM modes
module time_keeper #(
  parameter logic [6:0] SEC_MOD = 7'd60,
  parameter logic [6:0] MIN_MOD = 7'd60,
  parameter logic [6:0] HRS_MOD = 7'd24,
  parameter logic [6:0] DAY_MOD = 7'd7
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Timeset,
  input  logic       Alarmset,
  input  logic       Minadv,
  input  logic       Hrsadv,
  input  logic       Dayadv,
  output logic [6:0] tsec,
  output logic [6:0] tmin,
  output logic [6:0] thrs,
  output logic [6:0] tday,
  output logic [6:0] amin,
  output logic [6:0] ahrs,
  output logic [6:0] aday,
  output logic       sec_wrap
);

  typedef enum logic [1:0] {RUN, SET_TIME, SET_ALARM} state_t;

  state_t state;
  state_t next_state;
  logic   min_prev, hrs_prev, day_prev;
  logic   min_edge, hrs_edge, day_edge;

  function automatic logic [6:0] inc_mod(input logic [6:0] v, input logic [6:0] m);
    return (v == m - 7'd1) ? 7'd0 : v + 7'd1;
  endfunction

  assign min_edge = Minadv & ~min_prev;
  assign hrs_edge = Hrsadv & ~hrs_prev;
  assign day_edge = Dayadv & ~day_prev;

  always_comb begin
    next_state = RUN;
    if (Timeset)       next_state = SET_TIME;
    else if (Alarmset) next_state = SET_ALARM;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= RUN;
      // History starts high so a button held through reset release is not an edge
      min_prev <= 1'b1;
      hrs_prev <= 1'b1;
      day_prev <= 1'b1;
      tsec     <= 7'd0;
      tmin     <= 7'd0;
      thrs     <= 7'd0;
      tday     <= 7'd0;
      amin     <= 7'd0;
      ahrs     <= 7'd0;
      aday     <= 7'd0;
      sec_wrap <= 1'b0;
    end else begin
      state    <= next_state;
      min_prev <= Minadv;
      hrs_prev <= Hrsadv;
      day_prev <= Dayadv;
      sec_wrap <= 1'b0;

      case (state)
        RUN, SET_ALARM: begin
          if (Tick) begin
            tsec <= inc_mod(tsec, SEC_MOD);
            if (tsec == SEC_MOD - 7'd1) begin
              sec_wrap <= 1'b1;
              tmin     <= inc_mod(tmin, MIN_MOD);
              if (tmin == MIN_MOD - 7'd1) begin
                thrs <= inc_mod(thrs, HRS_MOD);
                if (thrs == HRS_MOD - 7'd1) tday <= inc_mod(tday, DAY_MOD);
              end
            end
          end
        end
        SET_TIME: begin
          if (min_edge) tmin <= inc_mod(tmin, MIN_MOD);
          if (hrs_edge) thrs <= inc_mod(thrs, HRS_MOD);
          if (day_edge) tday <= inc_mod(tday, DAY_MOD);
        end
        default: ;
      endcase

      if (state == SET_ALARM) begin
        if (min_edge) amin <= inc_mod(amin, MIN_MOD);
        if (hrs_edge) ahrs <= inc_mod(ahrs, HRS_MOD);
        if (day_edge) aday <= inc_mod(aday, DAY_MOD);
      end

      // Entering SET_TIME zeroes seconds and overrides any tick on the same edge
      if (next_state == SET_TIME && state != SET_TIME) begin
        tsec     <= 7'd0;
        sec_wrap <= 1'b0;
      end
    end
  end

endmodule
